// File: rtl/watermark_pkg.sv
// Shared widths and state encoding for the block-scan sequencer.
package watermark_pkg;

    localparam int unsigned SIZE_W     = 10;
    localparam int unsigned ADDR_W     = 20;
    localparam int unsigned Data_Depth = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } scan_state_t;

endpackage

// File: rtl/block_scan_ctrl_if.sv
// Control, pixel-memory and pixel-output signals of the block-scan sequencer.
interface block_scan_ctrl_if;
    import watermark_pkg::*;

    logic                  start;
    logic [SIZE_W-1:0]     img_size;
    logic [SIZE_W-1:0]     M;
    logic                  pix_ready;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [Data_Depth-1:0] rd_data;
    logic [Data_Depth-1:0] Pixel_Data;
    logic                  new_pixel;
    logic                  block_done;
    logic                  Image_Done;
    logic                  busy;
    logic                  cfg_err;

    modport master (
        input  start, img_size, M, pix_ready, rd_data,
        output rd_en, rd_addr, Pixel_Data, new_pixel, block_done,
               Image_Done, busy, cfg_err
    );

    modport slave (
        output start, img_size, M, pix_ready, rd_data,
        input  rd_en, rd_addr, Pixel_Data, new_pixel, block_done,
               Image_Done, busy, cfg_err
    );

endinterface

// File: rtl/block_addr_gen.sv
// Block-order address walker: column/row counters inside a block, block and strip
// offsets, and running base addresses. Adders only.
module block_addr_gen
    import watermark_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [SIZE_W-1:0] n_i,
    input  logic [SIZE_W-1:0] m_i,
    output logic [ADDR_W-1:0] rd_addr_c,
    output logic              last_in_block_c,
    output logic              last_in_image_c
);

    localparam int unsigned SW1 = SIZE_W + 1;

    // bc_q / sr_q hold the block column / strip row offsets in pixels (index * M)
    logic [SIZE_W-1:0] c_q, c_d, r_q, r_d, bc_q, bc_d, sr_q, sr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, blk_base_q, blk_base_d;
    logic [ADDR_W-1:0] strip_base_q, strip_base_d;
    logic              c_last, r_last, bc_last, sr_last;

    assign c_last  = (c_q == m_i - SIZE_W'(1));
    assign r_last  = (r_q == m_i - SIZE_W'(1));
    assign bc_last = (SW1'(bc_q) + SW1'(m_i)) >= SW1'(n_i);
    assign sr_last = (SW1'(sr_q) + SW1'(m_i)) >= SW1'(n_i);

    assign rd_addr_c       = row_base_q + ADDR_W'(c_q);
    assign last_in_block_c = c_last && r_last;
    assign last_in_image_c = c_last && r_last && bc_last && sr_last;

    always_comb begin
        c_d          = c_q;
        r_d          = r_q;
        bc_d         = bc_q;
        sr_d         = sr_q;
        row_base_d   = row_base_q;
        blk_base_d   = blk_base_q;
        strip_base_d = strip_base_q;
        if (clr_i) begin
            c_d          = '0;
            r_d          = '0;
            bc_d         = '0;
            sr_d         = '0;
            row_base_d   = '0;
            blk_base_d   = '0;
            strip_base_d = '0;
        end else if (adv_i) begin
            if (!c_last) begin
                c_d = c_q + SIZE_W'(1);
            end else begin
                c_d = '0;
                if (!r_last) begin
                    r_d        = r_q + SIZE_W'(1);
                    row_base_d = row_base_q + ADDR_W'(n_i);
                end else begin
                    r_d = '0;
                    if (!bc_last) begin
                        bc_d       = bc_q + m_i;
                        blk_base_d = blk_base_q + ADDR_W'(m_i);
                        row_base_d = blk_base_q + ADDR_W'(m_i);
                    end else begin
                        // row_base is strip_base + bc + (M-1)*N here
                        bc_d         = '0;
                        sr_d         = sr_q + m_i;
                        strip_base_d = row_base_q + ADDR_W'(n_i) - ADDR_W'(bc_q);
                        blk_base_d   = strip_base_d;
                        row_base_d   = strip_base_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q          <= '0;
            r_q          <= '0;
            bc_q         <= '0;
            sr_q         <= '0;
            row_base_q   <= '0;
            blk_base_q   <= '0;
            strip_base_q <= '0;
        end else begin
            c_q          <= c_d;
            r_q          <= r_d;
            bc_q         <= bc_d;
            sr_q         <= sr_d;
            row_base_q   <= row_base_d;
            blk_base_q   <= blk_base_d;
            strip_base_q <= strip_base_d;
        end
    end

endmodule

// File: rtl/block_scan_ctrl.sv
// Walks an NxN image in MxM blocks, reads pixel memory and strobes pixels downstream.
// Optional configuration checking is enabled with BLOCK_SCAN_CFG_CHECK_EN.
module block_scan_ctrl
    import watermark_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    block_scan_ctrl_if.master bus
);

    scan_state_t           state_q, state_d;
    logic [SIZE_W-1:0]     n_q, n_d, m_q, m_d;
    logic                  adv, clr;
    logic [ADDR_W-1:0]     addr_c;
    logic                  last_blk_c, last_img_c;
    logic                  rd_en_q, blk_last_q, new_pixel_q, block_done_q;
    logic                  image_done_q, busy_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [Data_Depth-1:0] pixel_q;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
    logic [SIZE_W-1:0]     rem_q, rem_d;
    logic                  cfg_err_q, cfg_err_d;
`endif

    block_addr_gen u_addr (
        .clk             (clk),
        .rst             (rst),
        .clr_i           (clr),
        .adv_i           (adv),
        .n_i             (n_q),
        .m_i             (m_q),
        .rd_addr_c       (addr_c),
        .last_in_block_c (last_blk_c),
        .last_in_image_c (last_img_c)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        adv     = 1'b0;
        clr     = 1'b0;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
        rem_d     = rem_q;
        cfg_err_d = cfg_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    n_d     = bus.img_size;
                    m_d     = bus.M;
                    clr     = 1'b1;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
                    rem_d     = bus.img_size;
                    cfg_err_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
`ifdef BLOCK_SCAN_CFG_CHECK_EN
                // N mod M by one subtraction per cycle
                if (m_q == '0 || n_q == '0 || m_q > n_q) begin
                    state_d   = S_ERR;
                    cfg_err_d = 1'b1;
                end else if (rem_q >= m_q) begin
                    rem_d = rem_q - m_q;
                end else if (rem_q == '0) begin
                    state_d = S_SCAN;
                end else begin
                    state_d   = S_ERR;
                    cfg_err_d = 1'b1;
                end
`else
                state_d = S_SCAN;
`endif
            end
            S_SCAN: begin
                if (bus.pix_ready) begin
                    adv = 1'b1;
                    if (last_img_c) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            m_q          <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            blk_last_q   <= 1'b0;
            new_pixel_q  <= 1'b0;
            pixel_q      <= '0;
            block_done_q <= 1'b0;
            image_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
            rem_q        <= '0;
            cfg_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            m_q          <= m_d;
            rd_en_q      <= adv;
            rd_addr_q    <= adv ? addr_c : rd_addr_q;
            blk_last_q   <= adv && last_blk_c;
            // memory data for the read issued last cycle is valid now
            new_pixel_q  <= rd_en_q;
            pixel_q      <= rd_en_q ? bus.rd_data : pixel_q;
            block_done_q <= blk_last_q;
            image_done_q <= (state_q == S_DONE);
            busy_q       <= (state_d != S_IDLE);
`ifdef BLOCK_SCAN_CFG_CHECK_EN
            rem_q        <= rem_d;
            cfg_err_q    <= cfg_err_d;
`endif
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.Pixel_Data = pixel_q;
    assign bus.new_pixel  = new_pixel_q;
    assign bus.block_done = block_done_q;
    assign bus.Image_Done = image_done_q;
    assign bus.busy       = busy_q;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
    assign bus.cfg_err    = cfg_err_q;
`else
    assign bus.cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_block_scan_ctrl.sv
// Directed bench for block_scan_ctrl: table of scan configurations plus reset and
// mid-scan start sequences; honours BLOCK_SCAN_CFG_CHECK_EN.
module tb_block_scan_ctrl;
    import watermark_pkg::*;

    typedef struct {
        int n;
        int m;
        bit stall;
        bit legal;
        bit poke;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    block_scan_ctrl_if bus ();

    block_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [Data_Depth-1:0] pix_of(input logic [ADDR_W-1:0] a);
        return Data_Depth'(a) ^ Data_Depth'(a >> 8) ^ Data_Depth'(8'h5A);
    endfunction

    // asynchronous-read memory on the registered address
    assign bus.rd_data = bus.rd_en ? pix_of(bus.rd_addr) : '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"},      longint'(bus.rd_en),      0);
        chk({tag, "_rd_addr"},    longint'(bus.rd_addr),    0);
        chk({tag, "_pixel"},      longint'(bus.Pixel_Data), 0);
        chk({tag, "_new_pixel"},  longint'(bus.new_pixel),  0);
        chk({tag, "_block_done"}, longint'(bus.block_done), 0);
        chk({tag, "_image_done"}, longint'(bus.Image_Done), 0);
        chk({tag, "_busy"},       longint'(bus.busy),       0);
        chk({tag, "_cfg_err"},    longint'(bus.cfg_err),    0);
    endtask

    function automatic int load_cycles(input int n, input int m);
`ifdef BLOCK_SCAN_CFG_CHECK_EN
        return n / m + 1;
`else
        return 1 + 0 * (n + m);
`endif
    endfunction

    task automatic run_scan(input vector_t v);
        int exp[$];
        int seq42[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int rd_i = 0;
        int px_i = 0;
        int j_done = -1;
        int last_pix = -1;
        int exp_lat;
        bit saw_err = 1'b0;
        bit exp_err;
`ifdef BLOCK_SCAN_CFG_CHECK_EN
        exp_err = !v.legal;
`else
        exp_err = 1'b0;
`endif
        if (v.legal) begin
            if (v.n == 4 && v.m == 2) begin
                foreach (seq42[i]) exp.push_back(seq42[i]);
            end else begin
                for (int s = 0; s < v.n / v.m; s++)
                    for (int b = 0; b < v.n / v.m; b++)
                        for (int r = 0; r < v.m; r++)
                            for (int c = 0; c < v.m; c++)
                                exp.push_back((s * v.m + r) * v.n + b * v.m + c);
            end
            exp_lat = load_cycles(v.n, v.m) + v.n * v.n + 2 + (v.stall ? v.n * v.n : 0);
        end else begin
            exp_lat = 0;
        end

        bus.img_size  = SIZE_W'(v.n);
        bus.M         = SIZE_W'(v.m);
        bus.start     = 1'b1;
        bus.pix_ready = !v.stall;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_on_start", longint'(bus.busy), 1);
        chk("cfg_err_cleared", longint'(bus.cfg_err), 0);

        for (int j = 1; j < 400; j++) begin
            if (v.poke) begin
                bus.start    = (j == 10);
                bus.img_size = (j == 10) ? SIZE_W'(8) : SIZE_W'(v.n);
            end
            bus.pix_ready = v.stall ? (j % 2 == 1) : 1'b1;
            @(posedge clk);
            #1;
            if (bus.rd_en) begin
                if (exp_err) chk("rd_en_on_err", longint'(bus.rd_en), 0);
                else if (v.legal && rd_i < exp.size())
                    chk("rd_addr", longint'(bus.rd_addr), exp[rd_i]);
                rd_i++;
            end
            if (bus.new_pixel) begin
                if (v.legal && px_i < exp.size()) begin
                    last_pix = int'(pix_of(ADDR_W'(exp[px_i])));
                    chk("pixel", longint'(bus.Pixel_Data), last_pix);
                    chk("block_done", longint'(bus.block_done),
                        longint'((px_i + 1) % (v.m * v.m) == 0));
                end
                px_i++;
            end else begin
                chk("block_done_idle", longint'(bus.block_done), 0);
                if (v.legal && last_pix >= 0)
                    chk("pixel_hold", longint'(bus.Pixel_Data), last_pix);
            end
            if (bus.cfg_err) saw_err = 1'b1;
            if (bus.Image_Done) begin
                j_done = j;
                break;
            end
            if (exp_err && saw_err && !bus.busy) break;
        end
        bus.start = 1'b0;

        if (exp_err) begin
            chk("cfg_err_seen", longint'(saw_err), 1);
            chk("rd_count_err", rd_i, 0);
            chk("busy_after_err", longint'(bus.busy), 0);
            chk("no_done_on_err", j_done, -1);
            repeat (3) @(posedge clk);
            #1;
            chk("cfg_err_sticky", longint'(bus.cfg_err), 1);
        end else begin
            chk("cfg_err_none", longint'(saw_err), 0);
            chk("image_done_seen", longint'(j_done > 0), 1);
            if (v.legal) begin
                chk("rd_count", rd_i, exp.size());
                chk("px_count", px_i, exp.size());
                chk("done_latency", j_done, exp_lat);
            end
            chk("busy_at_done", longint'(bus.busy), 0);
            @(posedge clk);
            #1;
            chk("done_pulse_width", longint'(bus.Image_Done), 0);
        end
    endtask

    initial begin
        vector_t vecs[$];
        int      cnt;
        bit      seen_done;

        vecs.push_back('{n: 4, m: 2, stall: 1'b0, legal: 1'b1, poke: 1'b0});
        vecs.push_back('{n: 1, m: 1, stall: 1'b0, legal: 1'b1, poke: 1'b0});
        vecs.push_back('{n: 6, m: 4, stall: 1'b0, legal: 1'b0, poke: 1'b0});
        vecs.push_back('{n: 4, m: 2, stall: 1'b1, legal: 1'b1, poke: 1'b0});
        vecs.push_back('{n: 3, m: 3, stall: 1'b0, legal: 1'b1, poke: 1'b0});
        vecs.push_back('{n: 6, m: 3, stall: 1'b0, legal: 1'b1, poke: 1'b0});
        vecs.push_back('{n: 4, m: 8, stall: 1'b0, legal: 1'b0, poke: 1'b0});
        vecs.push_back('{n: 4, m: 2, stall: 1'b0, legal: 1'b1, poke: 1'b1});
`ifdef BLOCK_SCAN_CFG_CHECK_EN
        vecs.push_back('{n: 4, m: 0, stall: 1'b0, legal: 1'b0, poke: 1'b0});
        vecs.push_back('{n: 0, m: 2, stall: 1'b0, legal: 1'b0, poke: 1'b0});
        vecs.push_back('{n: 2, m: 2, stall: 1'b0, legal: 1'b1, poke: 1'b0});
`endif

        bus.start     = 1'b0;
        bus.img_size  = '0;
        bus.M         = '0;
        bus.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        foreach (vecs[i]) run_scan(vecs[i]);

        // reset on the 5th read aborts the scan
        bus.img_size  = SIZE_W'(4);
        bus.M         = SIZE_W'(2);
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(posedge clk);
            #1;
            if (bus.rd_en) cnt++;
            if (cnt == 5) break;
        end
        chk("fifth_rd_en", cnt, 5);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_mid");
        rst = 1'b1;
        seen_done = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            if (bus.Image_Done) seen_done = 1'b1;
        end
        chk("no_done_after_rst", longint'(seen_done), 0);
        chk("idle_after_rst", longint'(bus.busy), 0);
        run_scan(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
